// File: rtl/axi_write_arbiter.sv
// Two-requester arbiter for the AXI write channel: D-cache writeback vs uncached store.
// Round-robin on ties, grant held until the final beat, busy/address status for RAW stalls.
module axi_write_arbiter #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dc_w_valid,
  output logic                      dc_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] dc_w_data,
  input  logic [AXI_ADDR_WIDTH-1:0] dc_w_addr,
  input  logic [7:0]                dc_w_len,
  input  logic [2:0]                dc_w_size,
  output logic                      dc_w_last_i,
  input  logic                      uc_w_valid,
  output logic                      uc_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] uc_w_data,
  input  logic [AXI_ADDR_WIDTH-1:0] uc_w_addr,
  input  logic [7:0]                uc_w_len,
  input  logic [2:0]                uc_w_size,
  output logic                      uc_w_last_i,
  output logic                      w_valid_i,
  output logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
  output logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
  output logic [2:0]                w_size_i,
  output logic [7:0]                w_len_i,
  input  logic                      w_ready_o,
  input  logic                      w_last_i,
  output logic                      wr_busy,
  output logic [AXI_ADDR_WIDTH-1:0] wr_busy_addr,
  output logic                      len_err,
  output logic                      proto_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_DC = 2'd1,
    GNT_UC = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_rr_last;
  logic                      w_rr_last_nxt;
  logic [8:0]                r_beat_cnt;
  logic [8:0]                w_beat_cnt_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_busy_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_busy_addr_nxt;
  logic                      r_proto_err;
  logic                      w_valid_drop;
  logic                      w_pick_dc;
  logic                      w_pick_uc;
  logic                      w_done;
  logic                      w_sel_uc;
  logic                      w_gnt_valid;
  logic [7:0]                w_gnt_len;

  // rr_last == 1 means UC won last, so DC takes the tie
  assign w_pick_dc = dc_w_valid & (~uc_w_valid | r_rr_last);
  assign w_pick_uc = uc_w_valid & (~dc_w_valid | ~r_rr_last);
  assign w_sel_uc  = (r_state == GNT_UC);
  assign w_gnt_valid = w_sel_uc ? uc_w_valid : dc_w_valid;
  assign w_gnt_len   = w_sel_uc ? uc_w_len : dc_w_len;
  assign w_done      = w_ready_o & w_last_i;

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_last   <= 1'b1;
      r_beat_cnt  <= 9'd0;
      r_busy_addr <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_last   <= w_rr_last_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_busy_addr <= w_busy_addr_nxt;
      r_proto_err <= r_proto_err | w_valid_drop;
    end
  end

  // Next-state and combinational pass-through of the granted requester
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_last_nxt   = r_rr_last;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_busy_addr_nxt = r_busy_addr;
    w_valid_drop    = 1'b0;
    dc_w_ready      = 1'b0;
    dc_w_last_i     = 1'b0;
    uc_w_ready      = 1'b0;
    uc_w_last_i     = 1'b0;
    w_valid_i       = 1'b0;
    rw_w_data_i     = '0;
    w_addr_i        = '0;
    w_size_i        = 3'd0;
    w_len_i         = 8'd0;
    len_err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_dc) begin
          w_state_nxt     = GNT_DC;
          w_rr_last_nxt   = 1'b0;
          w_busy_addr_nxt = dc_w_addr;
          w_beat_cnt_nxt  = 9'd0;
        end else if (w_pick_uc) begin
          w_state_nxt     = GNT_UC;
          w_rr_last_nxt   = 1'b1;
          w_busy_addr_nxt = uc_w_addr;
          w_beat_cnt_nxt  = 9'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT_DC, GNT_UC: begin
        w_valid_i    = 1'b1;
        w_valid_drop = ~w_gnt_valid;
        if (w_sel_uc) begin
          rw_w_data_i = uc_w_data;
          w_addr_i    = uc_w_addr;
          w_size_i    = uc_w_size;
          w_len_i     = uc_w_len;
          uc_w_ready  = w_ready_o;
          uc_w_last_i = w_done;
        end else begin
          rw_w_data_i = dc_w_data;
          w_addr_i    = dc_w_addr;
          w_size_i    = dc_w_size;
          w_len_i     = dc_w_len;
          dc_w_ready  = w_ready_o;
          dc_w_last_i = w_done;
        end
        if (w_ready_o && (r_beat_cnt != 9'h1FF)) begin
          w_beat_cnt_nxt = r_beat_cnt + 9'd1;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
        // Grant cannot be cancelled, so only the final beat releases it
        if (w_done) begin
          w_state_nxt = IDLE;
          len_err     = (r_beat_cnt != {1'b0, w_gnt_len});
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign wr_busy      = (r_state != IDLE);
  assign wr_busy_addr = wr_busy ? r_busy_addr : '0;
  assign proto_err    = r_proto_err;

endmodule
